analog_bus_sequencer: RTL and testbench

Transaction sequencer that sits directly upstream of a tri-state bus driver port (the `port_0_in_valid` / `port_0_in_bits` / `port_0_out` triple of an indexed analog bus agent). It accepts write and read requests over a ready/valid interface and performs one bus access at a time:
- drives write data for a fixed hold window, samples the readback, then releases the bus for a turnaround gap before responding;
- checks write readback against the agent's known index offset and counts mismatches.

---
 rtl/analog_bus_pkg.sv | 30 +++
 rtl/analog_bus_sequencer.sv | 148 ++++++++++++++
 tb/tb_analog_bus_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/analog_bus_pkg.sv
// Shared types and constants for the analog bus sequencer.
//   seqState_t  : sequencer FSM states
//   ERR_COUNT_W : width of the saturating mismatch counter
//   BUS_W       : default bus/data width of the agent
//   bus_req_t   : one request record {write, data} at the default width
//   satInc      : saturating increment for the mismatch counter
package analog_bus_pkg;

    localparam int ERR_COUNT_W = 8;
    localparam int BUS_W       = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_TURN,
        ST_SAMPLE,
        ST_RESP
    } seqState_t;

    typedef struct packed {
        logic             write;
        logic [BUS_W-1:0] data;
    } bus_req_t;

    // The counter sticks at all-ones instead of wrapping back to zero.
    function automatic logic [ERR_COUNT_W-1:0] satInc(input logic [ERR_COUNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/analog_bus_sequencer.sv
// Transaction sequencer in front of a tri-state bus agent port.
// Performs one access at a time: a write drives the bus for HOLD_CYCLES,
// samples the readback on the last drive cycle, releases the bus for
// TURN_CYCLES and then responds; a read samples the bus for one cycle and
// responds. Write readback is compared against data + INDEX.
//
// Ports:
//   clock, reset_n             : clock, async active-low reset
//   req_valid/ready/write/data : request channel
//   drive_valid, drive_bits    : to agent port_0_in_valid / port_0_in_bits
//   bus_in                     : from agent port_0_out (resolved bus value)
//   rsp_valid/ready/data       : response channel
//   rsp_mismatch               : write readback differed from expectation
//   err_count                  : saturating count of mismatching writes
module analog_bus_sequencer
    import analog_bus_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int INDEX       = 0,
    parameter int HOLD_CYCLES = 2,
    parameter int TURN_CYCLES = 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [WIDTH-1:0]       req_data,
    output logic                   drive_valid,
    output logic [WIDTH-1:0]       drive_bits,
    input  logic [WIDTH-1:0]       bus_in,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   rsp_mismatch,
    output logic [ERR_COUNT_W-1:0] err_count
);

    // One down-counter serves both the hold and the turnaround windows.
    localparam int MAX_CYC = (HOLD_CYCLES > TURN_CYCLES) ? HOLD_CYCLES : TURN_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

    seqState_t               state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]        reqData_q, reqData_d;
    logic [WIDTH-1:0]        rspData_q, rspData_d;
    logic                    rspMismatch_q, rspMismatch_d;
    logic [ERR_COUNT_W-1:0]  errCount_q, errCount_d;
    logic [WIDTH-1:0]        expected;

    // The agent adds INDEX to whatever we drive; the carry is dropped.
    assign expected = reqData_q + WIDTH'(INDEX);

    // State and datapath registers; reset discards any in-flight access.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            reqData_q     <= '0;
            rspData_q     <= '0;
            rspMismatch_q <= 1'b0;
            errCount_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            reqData_q     <= reqData_d;
            rspData_q     <= rspData_d;
            rspMismatch_q <= rspMismatch_d;
            errCount_q    <= errCount_d;
        end
    end

    // Next-state logic. The write/read choice is carried by the state
    // itself (DRIVE vs SAMPLE), so only the data needs a register.
    // The error counter bumps on the transition into RESP.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        reqData_d     = reqData_q;
        rspData_d     = rspData_q;
        rspMismatch_d = rspMismatch_q;
        errCount_d    = errCount_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    reqData_d = req_data;
                    if (req_write) begin
                        state_d = ST_DRIVE;
                        cnt_d   = HOLD_LOAD;
                    end else begin
                        state_d = ST_SAMPLE;
                    end
                end
            end
            ST_DRIVE: begin
                if (cnt_q == '0) begin
                    rspData_d     = bus_in;
                    rspMismatch_d = (bus_in != expected);
                    if (TURN_CYCLES > 0) begin
                        state_d = ST_TURN;
                        cnt_d   = TURN_LOAD;
                    end else begin
                        state_d = ST_RESP;
                        if (bus_in != expected) begin
                            errCount_d = satInc(errCount_q);
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_TURN: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    if (rspMismatch_q) begin
                        errCount_d = satInc(errCount_q);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SAMPLE: begin
                rspData_d     = bus_in;
                rspMismatch_d = 1'b0;
                state_d       = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode straight from the state so reset clears them at once;
    // the data port is forced to zero whenever we are not driving.
    assign req_ready    = (state_q == ST_IDLE);
    assign drive_valid  = (state_q == ST_DRIVE);
    assign drive_bits   = drive_valid ? reqData_q : '0;
    assign rsp_valid    = (state_q == ST_RESP);
    assign rsp_data     = rspData_q;
    assign rsp_mismatch = rspMismatch_q;
    assign err_count    = errCount_q;

endmodule

// File: tb/tb_analog_bus_sequencer.sv
// Self-checking bench for analog_bus_sequencer. A behavioural agent model
// adds INDEX to driven data; a second writer can override the bus.
module tb_analog_bus_sequencer;
    import analog_bus_pkg::*;

    localparam int WIDTH = 32;
    localparam int INDEX = 3;
    localparam int HOLD  = 2;
    localparam int TURN  = 1;

    logic             clock;
    logic             reset_n;
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [WIDTH-1:0] req_data;
    logic             drive_valid;
    logic [WIDTH-1:0] drive_bits;
    logic [WIDTH-1:0] bus_in;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_mismatch;
    logic [7:0]       err_count;

    logic             forceEn;
    logic [WIDTH-1:0] forceVal;
    logic [WIDTH-1:0] idleVal;

    int checks;
    int failures;
    int errModel;

    typedef struct packed {
        bus_req_t    req;
        logic        ovr;
        logic [31:0] ovrVal;
        logic [31:0] expData;
        logic        expMm;
        logic [3:0]  rspHold;
    } vec_t;

    vec_t vecs [6];

    analog_bus_sequencer #(
        .WIDTH(WIDTH), .INDEX(INDEX), .HOLD_CYCLES(HOLD), .TURN_CYCLES(TURN)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_data(req_data),
        .drive_valid(drive_valid), .drive_bits(drive_bits),
        .bus_in(bus_in),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_mismatch(rsp_mismatch),
        .err_count(err_count)
    );

    // Agent model: combinational bus, a second writer wins when enabled.
    assign bus_in = forceEn ? forceVal :
                    (drive_valid ? drive_bits + 32'(INDEX) : idleVal);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // One full transaction: request handshake, per-cycle port checks,
    // response checks, rspHold cycles of back-pressure with a competing
    // request, then the response handshake.
    task automatic applyStimulus(input logic wr, input logic [31:0] data,
                                 input logic ovr, input logic [31:0] ovrVal,
                                 input logic [31:0] expData, input logic expMm,
                                 input int rspHold, input string tag);
        int  k;
        int  driveCnt;
        bit  gotRsp;
        int  expLat;
        driveCnt = 0;
        gotRsp   = 0;
        expLat   = wr ? HOLD + TURN + 1 : 2;
        @(negedge clock);
        checkOutput({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
        forceEn   = ovr;
        forceVal  = ovrVal;
        req_valid = 1'b1;
        req_write = wr;
        req_data  = data;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_data  = $urandom;
        k = 0;
        while (!gotRsp && k < 50) begin
            @(negedge clock);
            k++;
            if (drive_valid) driveCnt++;
            checkOutput({tag, "_drive_bits"}, drive_bits, drive_valid ? data : 32'd0);
            if (rsp_valid) gotRsp = 1;
            else checkOutput({tag, "_ready_busy"}, 32'(req_ready), 32'd0);
        end
        checkOutput({tag, "_rsp_seen"}, 32'(gotRsp), 32'd1);
        if (expMm && errModel < 255) errModel++;
        if (gotRsp) begin
            checkOutput({tag, "_latency"}, 32'(k), 32'(expLat));
            checkOutput({tag, "_drive_cycles"}, 32'(driveCnt), wr ? 32'(HOLD) : 32'd0);
            checkOutput({tag, "_rsp_data"}, rsp_data, expData);
            checkOutput({tag, "_rsp_mismatch"}, 32'(rsp_mismatch), 32'(expMm));
            checkOutput({tag, "_err_count"}, 32'(err_count), 32'(errModel));
            req_valid = (rspHold > 0);
            req_write = 1'($urandom);
            req_data  = $urandom;
            for (int i = 0; i < rspHold; i++) begin
                @(negedge clock);
                checkOutput({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
                checkOutput({tag, "_hold_data"}, rsp_data, expData);
                checkOutput({tag, "_hold_mm"}, 32'(rsp_mismatch), 32'(expMm));
                checkOutput({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
                checkOutput({tag, "_hold_nodrive"}, 32'(drive_valid), 32'd0);
            end
            rsp_ready = 1'b1;
            @(posedge clock);
            #1;
            rsp_ready = 1'b0;
            req_valid = 1'b0;
            forceEn   = 1'b0;
            @(negedge clock);
            checkOutput({tag, "_post_rsp_valid"}, 32'(rsp_valid), 32'd0);
            checkOutput({tag, "_post_ready"}, 32'(req_ready), 32'd1);
        end else begin
            req_valid = 1'b0;
            forceEn   = 1'b0;
        end
    endtask

    initial begin
        logic        wr;
        logic [31:0] data;
        logic        ovr;
        logic [31:0] ovrVal;
        logic [31:0] expData;
        logic        expMm;

        checks    = 0;
        failures  = 0;
        errModel  = 0;
        forceEn   = 1'b0;
        forceVal  = '0;
        idleVal   = '0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_data  = '0;
        rsp_ready = 1'b0;
        reset_n   = 1'b0;

        // {write,data}, ovr, ovrVal, expData, expMm, rspHold
        vecs[0] = '{'{1'b1, 32'h10},       1'b0, 32'h0,    32'h13,       1'b0, 4'd0};
        vecs[1] = '{'{1'b1, 32'hFFFFFFFF}, 1'b0, 32'h0,    32'h00000002, 1'b0, 4'd0};
        vecs[2] = '{'{1'b1, 32'h10},       1'b1, 32'hDEAD, 32'hDEAD,     1'b1, 4'd0};
        vecs[3] = '{'{1'b0, 32'h1234},     1'b1, 32'hA5,   32'hA5,       1'b0, 4'd0};
        vecs[4] = '{'{1'b1, 32'h55},       1'b0, 32'h0,    32'h58,       1'b0, 4'd5};
        vecs[5] = '{'{1'b0, 32'h0},        1'b1, 32'h77,   32'h77,       1'b0, 4'd5};

        #12;
        checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_drive_valid", 32'(drive_valid), 32'd0);
        checkOutput("reset_drive_bits", drive_bits, 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_data", rsp_data, 32'd0);
        checkOutput("reset_err_count", 32'(err_count), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].req.write, vecs[i].req.data, vecs[i].ovr,
                          vecs[i].ovrVal, vecs[i].expData, vecs[i].expMm,
                          int'(vecs[i].rspHold), $sformatf("vec%0d", i));
        end

        // Random traffic checked against the rule-level model.
        for (int i = 0; i < 40; i++) begin
            wr      = 1'($urandom);
            data    = $urandom;
            ovr     = ($urandom_range(0, 3) == 0);
            ovrVal  = $urandom;
            idleVal = $urandom;
            expData = ovr ? ovrVal : (wr ? data + 32'(INDEX) : idleVal);
            expMm   = wr && (expData != data + 32'(INDEX));
            applyStimulus(wr, data, ovr, ovrVal, expData, expMm,
                          $urandom_range(0, 3), $sformatf("rnd%0d", i));
        end

        // Mismatching writes until the counter must have saturated.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 32'h10, 1'b1, 32'hDEAD, 32'hDEAD, 1'b1, 0, "sat");
        end
        checkOutput("sat_final", 32'(err_count), 32'd255);

        // Reset in the middle of a write drive window.
        @(negedge clock);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_data  = 32'hCAFE;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(negedge clock);
        checkOutput("mid_drive_valid", 32'(drive_valid), 32'd1);
        checkOutput("mid_drive_bits", drive_bits, 32'hCAFE);
        #2;
        reset_n = 1'b0;
        #1;
        errModel = 0;
        checkOutput("rst_drive_valid", 32'(drive_valid), 32'd0);
        checkOutput("rst_drive_bits", drive_bits, 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_err_count", 32'(err_count), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            checkOutput("rst_no_rsp", 32'(rsp_valid), 32'd0);
            checkOutput("rst_idle_ready", 32'(req_ready), 32'd1);
        end
        idleVal = 32'h3C3C;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h3C3C, 1'b0, 1, "post_rst_read");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
